rfrsh_rnd_feeder: RTL and testbench

Prefetch buffer supplying refresh randomness to the masked key holder. It sits between the PRNG output port and the key holder's `rnd_rfrsh_in`/`rnd_rfrsh_in_valid` inputs. It pulls (d-1)·RFRSH_RATE-bit words from the PRNG ahead of time, so a refresh burst, which consumes up to 32 words back-to-back, is not stalled by PRNG latency. A hysteresis FSM throttles PRNG requests between a full buffer and a low-water mark.

---
 rtl/rfrsh_rnd_feeder_pkg.sv | 17 +
 rtl/rfrsh_rnd_feeder_mem.sv | 45 ++++
 rtl/rfrsh_rnd_feeder.sv | 118 +++++++++++
 tb/tb_rfrsh_rnd_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rfrsh_rnd_feeder_pkg.sv
// Shared constants for the refresh-randomness feeder: FSM encoding and width helpers.
package rfrsh_rnd_feeder_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    function automatic int word_w(input int d, input int rate);
        return (d - 1) * rate;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rfrsh_rnd_feeder_mem.sv
// DEPTH x W register array for the feeder; with SMAESH_RND_ZEROIZE_EN the
// entry being read can be wiped on pop and the whole array wiped on flush.
module rnd_fifo_mem
    import rfrsh_rnd_feeder_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
`ifdef SMAESH_RND_ZEROIZE_EN
    input  logic          clr_en,
    input  logic          clr_all,
`endif
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
`ifdef SMAESH_RND_ZEROIZE_EN
            if (clr_all) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else begin
                // a pop and a push never target the same entry
                if (clr_en) mem[rd_addr] <= '0;
                if (wr_en)  mem[wr_addr] <= wr_data;
            end
`else
            if (wr_en) mem[wr_addr] <= wr_data;
`endif
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rfrsh_rnd_feeder.sv
// Prefetch FIFO between the PRNG and the key holder refresh input, with
// fill/hold hysteresis. Optional SMAESH_RND_ZEROIZE_EN wipes used randomness.
module rfrsh_rnd_feeder
    import rfrsh_rnd_feeder_pkg::*;
#(
    parameter int d          = 2,
    parameter int RFRSH_RATE = 16,
    parameter int DEPTH      = 4,
    parameter int LOW_WM     = 1,
    localparam int W         = word_w(d, RFRSH_RATE),
    localparam int CW        = cnt_w(DEPTH),
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          flush,
    output logic [CW-1:0] level,
    output logic          underflow
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LWM  = CW'(LOW_WM);

    fsm_t          state, state_nxt;
    logic          alive;
    logic          uf;
    logic          push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [W-1:0]  rd_word;

    assign out_valid = (count != '0);
    assign in_ready  = alive & ~flush & (state == FILL) & (count < FULL);
    assign push      = in_valid & in_ready;
    assign pop       = out_ready & out_valid;
    assign level     = count;
    assign underflow = uf;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FILL;
        end else begin
            unique case (state)
                FILL: if (count_nxt == FULL) state_nxt = HOLD;
                HOLD: if (count_nxt <= LWM)  state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            alive  <= 1'b0;
            uf     <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            count <= count_nxt;
            if (flush) begin
                uf     <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (out_ready & ~out_valid) uf <= 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    rnd_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
`ifdef SMAESH_RND_ZEROIZE_EN
        .clr_en  (pop),
        .clr_all (flush),
`endif
        .rd_data (rd_word)
    );

`ifdef SMAESH_RND_ZEROIZE_EN
    assign out_data = out_valid ? rd_word : '0;
`else
    assign out_data = rd_word;
`endif

endmodule

// File: tb/tb_rfrsh_rnd_feeder.sv
// Bench for rfrsh_rnd_feeder: queue-based reference model, directed scenarios
// and a randomized run (SMAESH_RND_ZEROIZE_EN selects the zeroize expectations).
module tb_rfrsh_rnd_feeder;

    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int LOW_WM = 1;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          in_ready, out_valid, underflow;
    logic [W-1:0]  out_data;
    logic [CW-1:0] level;

    rfrsh_rnd_feeder #(
        .d          (2),
        .RFRSH_RATE (16),
        .DEPTH      (DEPTH),
        .LOW_WM     (LOW_WM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .level     (level),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: word queue, hysteresis flag, sticky underflow, alive
    logic [W-1:0] q[$];
    bit m_alive = 1'b0;
    bit m_hold = 1'b0;
    bit m_uf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, compare, clock, update model.
    task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                        input bit fl, output bit pushed);
        bit exp_rdy;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        flush = fl;
        #1;
        exp_rdy = m_alive && !fl && !m_hold && (q.size() < DEPTH);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid}, (q.size() != 0) ? 1 : 0);
        chk("level", {29'b0, level}, q.size());
        chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
        if (q.size() != 0) chk("out_data", {16'b0, out_data}, {16'b0, q[0]});
`ifdef SMAESH_RND_ZEROIZE_EN
        else chk("out_data_zero", {16'b0, out_data}, 0);
`endif
        pushed = iv && exp_rdy;
        @(posedge clk);
        m_alive = 1'b1;
        if (fl) begin
            q.delete();
            m_hold = 1'b0;
            m_uf = 1'b0;
        end else begin
            if (ordy && q.size() == 0) m_uf = 1'b1;
            else if (ordy) void'(q.pop_front());
            if (pushed) q.push_back(id);
            if (q.size() == DEPTH) m_hold = 1'b1;
            else if (q.size() <= LOW_WM) m_hold = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied between edges, checked before any clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {16'b0, out_data}, 0);
        chk("rst_level", {29'b0, level}, 0);
        chk("rst_underflow", {31'b0, underflow}, 0);
        q.delete();
        m_hold = 1'b0;
        m_uf = 1'b0;
        m_alive = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_at_release", {31'b0, in_ready}, 0);
    endtask

    initial begin
        bit p;
        logic [W-1:0] w;
        logic [W-1:0] rd_exp;
        int budget;

        @(negedge clk);
        do_reset();

        // fill to full from reset release
        w = 16'h0001;
        budget = 0;
        while (q.size() < DEPTH && budget < 12) begin
            step(1'b1, w, 1'b0, 1'b0, p);
            if (p) w++;
            budget++;
        end
        chk("fill_level", {29'b0, level}, 4);
        chk("fill_cycles", budget, 5);
        chk("full_in_ready", {31'b0, in_ready}, 0);
        chk("full_head", {16'b0, out_data}, 16'h0001);

        // three pops while the PRNG keeps offering 0x0005
        step(1'b1, w, 1'b1, 1'b0, p);
`ifdef SMAESH_RND_ZEROIZE_EN
        chk("mem0_zeroized", {16'b0, dut.u_mem.mem[0]}, 0);
`else
        chk("mem0_stale", {16'b0, dut.u_mem.mem[0]}, 16'h0001);
`endif
        chk("pop1_level", {29'b0, level}, 3);
        chk("pop1_rdy", {31'b0, in_ready}, 0);
        step(1'b1, w, 1'b1, 1'b0, p);
        chk("pop2_level", {29'b0, level}, 2);
        chk("pop2_rdy", {31'b0, in_ready}, 0);
        step(1'b1, w, 1'b1, 1'b0, p);
        chk("pop3_level", {29'b0, level}, 1);
        chk("pop3_rdy", {31'b0, in_ready}, 1);
        step(1'b1, w, 1'b0, 1'b0, p);
        chk("refill_level", {29'b0, level}, 2);
        chk("order_4", {16'b0, out_data}, 16'h0004);
        step(1'b0, '0, 1'b1, 1'b0, p);
        chk("order_5", {16'b0, out_data}, 16'h0005);
        step(1'b0, '0, 1'b1, 1'b0, p);
        chk("drained", {31'b0, out_valid}, 0);
`ifdef SMAESH_RND_ZEROIZE_EN
        chk("empty_data_zero", {16'b0, out_data}, 0);
`endif

        // sustained one-word-per-cycle burst of 32 pops
        step(1'b0, '0, 1'b0, 1'b1, p);
        w = 16'h0100;
        rd_exp = w;
        step(1'b1, w, 1'b0, 1'b0, p);
        if (p) w++;
        for (int i = 0; i < 32; i++) begin
            chk("burst_valid", {31'b0, out_valid}, 1);
            chk("burst_data", {16'b0, out_data}, {16'b0, rd_exp});
            step(1'b1, w, 1'b1, 1'b0, p);
            if (p) w++;
            rd_exp++;
        end
        step(1'b0, '0, 1'b0, 1'b1, p);

        // underflow sets, level holds, flush clears
        step(1'b0, '0, 1'b1, 1'b0, p);
        chk("uf_set", {31'b0, underflow}, 1);
        chk("uf_level", {29'b0, level}, 0);
        step(1'b0, '0, 1'b0, 1'b1, p);
        chk("uf_clr", {31'b0, underflow}, 0);

        // flush beats a simultaneous push of 0xBEEF and a pop
        step(1'b1, 16'h0010, 1'b0, 1'b0, p);
        step(1'b1, 16'h0011, 1'b0, 1'b0, p);
        step(1'b1, 16'hBEEF, 1'b1, 1'b1, p);
        chk("fl_level", {29'b0, level}, 0);
        chk("fl_valid", {31'b0, out_valid}, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_fill_state", {31'b0, in_ready}, 1);

        // randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            bit iv, ordy, fl;
            iv = ($urandom_range(0, 3) != 0);
            ordy = (i % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 63) == 0);
            if (i == 1500) do_reset();
            step(iv, W'($urandom), ordy, fl, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
